// File: rtl/multi_step_counter.sv
// Multi-channel programmable step counter: per-channel stride, direction, terminal limit,
// reload value, sticky carry/borrow flag and optional one-shot stop.

module multi_step_counter_ch #(
    parameter int unsigned W       = 8,
    parameter bit          OneShot = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         down_i,
    input  logic [W-1:0] step_i,
    input  logic [W-1:0] limit_i,
    input  logic [W-1:0] rld_i,
    output logic [W-1:0] count_o,
    output logic         tc_o,
    output logic         ovf_o,
    output logic         done_o
);
    typedef enum logic {ARMED = 1'b0, DONE = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           tc_q, tc_d;
    logic           ovf_q, ovf_d;
    logic [W:0]     nxt;
    logic [W-1:0]   res;
    logic           cy;
    logic           hit;
    logic           take;

    // W+1 bit arithmetic: the top bit is carry going up and borrow going down
    always_comb begin
        nxt  = down_i ? ({1'b0, count_q} - {1'b0, step_i})
                      : ({1'b0, count_q} + {1'b0, step_i});
        res  = nxt[W-1:0];
        cy   = nxt[W];
        hit  = down_i ? (cy || (res <= limit_i)) : (cy || (res >= limit_i));
        take = en_i && (state_q == ARMED) && (step_i != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= ARMED;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i || load_i)           state_d = ARMED;
        else if (take && hit && OneShot) state_d = DONE;
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load_i) begin
            count_d = load_val_i;
            ovf_d   = 1'b0;
        end else if (take) begin
            if (cy) ovf_d = 1'b1;
            if (hit) begin
                tc_d    = 1'b1;
                count_d = OneShot ? limit_i : rld_i;
            end else begin
                count_d = res;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;
    assign done_o  = OneShot ? (state_q == DONE) : 1'b0;
endmodule

module multi_step_counter #(
    parameter int unsigned CounterWidth = 8,
    parameter int unsigned NumCh        = 4,
    parameter bit          OneShot      = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumCh-1:0]                    clear_i,
    input  logic [NumCh-1:0]                    load_i,
    input  logic [NumCh-1:0][CounterWidth-1:0]  load_val_i,
    input  logic [NumCh-1:0]                    en_i,
    input  logic [NumCh-1:0]                    down_i,
    input  logic [NumCh-1:0][CounterWidth-1:0]  step_i,
    input  logic [NumCh-1:0][CounterWidth-1:0]  limit_i,
    input  logic [NumCh-1:0][CounterWidth-1:0]  rld_i,
    output logic [NumCh-1:0][CounterWidth-1:0]  count_o,
    output logic [NumCh-1:0]                    tc_o,
    output logic [NumCh-1:0]                    ovf_o,
    output logic [NumCh-1:0]                    done_o
);
    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        multi_step_counter_ch #(
            .W       (CounterWidth),
            .OneShot (OneShot)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i[c]),
            .load_i     (load_i[c]),
            .load_val_i (load_val_i[c]),
            .en_i       (en_i[c]),
            .down_i     (down_i[c]),
            .step_i     (step_i[c]),
            .limit_i    (limit_i[c]),
            .rld_i      (rld_i[c]),
            .count_o    (count_o[c]),
            .tc_o       (tc_o[c]),
            .ovf_o      (ovf_o[c]),
            .done_o     (done_o[c])
        );
    end
endmodule

// File: tb/tb_multi_step_counter.sv
// Directed bench for multi_step_counter: a free-running and a one-shot instance share the
// same stimulus; each test task checks the instance it targets.

module tb_multi_step_counter;
    localparam int W  = 8;
    localparam int NC = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NC-1:0]         clear, load, en, down;
    logic [NC-1:0][W-1:0]  load_val, step, limit, rld;
    logic [NC-1:0][W-1:0]  cnt_f, cnt_o;
    logic [NC-1:0]         tc_f, ovf_f, done_f, tc_o, ovf_o, done_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_step_counter #(.CounterWidth(W), .NumCh(NC), .OneShot(1'b0)) u_fr (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .load_i(load), .load_val_i(load_val),
        .en_i(en), .down_i(down), .step_i(step), .limit_i(limit), .rld_i(rld),
        .count_o(cnt_f), .tc_o(tc_f), .ovf_o(ovf_f), .done_o(done_f)
    );

    multi_step_counter #(.CounterWidth(W), .NumCh(NC), .OneShot(1'b1)) u_os (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .load_i(load), .load_val_i(load_val),
        .en_i(en), .down_i(down), .step_i(step), .limit_i(limit), .rld_i(rld),
        .count_o(cnt_o), .tc_o(tc_o), .ovf_o(ovf_o), .done_o(done_o)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear = '0; load = '0; en = '0; down = '0;
        load_val = '0; step = '0; limit = '0; rld = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        en = '1;
        step = {8'd3, 8'd3, 8'd3, 8'd3};
        limit = '1;
        tick(); tick();
        checks++; if (cnt_f !== '0) begin errors++; $display("FAIL reset_count_fr got %h want 0", cnt_f); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL reset_count_os got %h want 0", cnt_o); end
        checks++; if ({tc_f, ovf_f, done_f, tc_o, ovf_o, done_o} !== '0) begin
            errors++; $display("FAIL reset_flags got %h want 0", {tc_f, ovf_f, done_f, tc_o, ovf_o, done_o});
        end
        rst_n = 1'b1;
        en = 4'b0001;
        step[0] = 8'd7;
        tick();
        checks++; if (cnt_f[0] !== 8'd7) begin errors++; $display("FAIL reset_pre_count got %0d want 7", cnt_f[0]); end
        rst_n = 1'b0;
        tick();
        checks++; if (cnt_f[0] !== 8'd0) begin errors++; $display("FAIL reset_mid_count got %0d want 0", cnt_f[0]); end
        rst_n = 1'b1;
    endtask

    task automatic test_free_up();
        int exp_c[4];
        logic exp_t[4];
        exp_c = '{3, 6, 9, 0};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        step[0] = 8'd3; limit[0] = 8'd10; rld[0] = 8'd0; en[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (cnt_f[0] !== exp_c[i][W-1:0]) begin
                errors++; $display("FAIL free_up_count[%0d] got %0d want %0d", i, cnt_f[0], exp_c[i]);
            end
            checks++; if (tc_f[0] !== exp_t[i]) begin
                errors++; $display("FAIL free_up_tc[%0d] got %b want %b", i, tc_f[0], exp_t[i]);
            end
        end
        checks++; if (ovf_f[0] !== 1'b0) begin errors++; $display("FAIL free_up_ovf got %b want 0", ovf_f[0]); end
        checks++; if (done_f[0] !== 1'b0) begin errors++; $display("FAIL free_up_done got %b want 0", done_f[0]); end
    endtask

    task automatic test_down_borrow();
        int exp_c[3];
        exp_c = '{3, 1, 200};
        apply_reset();
        load[1] = 1'b1; load_val[1] = 8'd5;
        tick();
        checks++; if (cnt_f[1] !== 8'd5) begin errors++; $display("FAIL down_load got %0d want 5", cnt_f[1]); end
        load[1] = 1'b0;
        down[1] = 1'b1; step[1] = 8'd2; limit[1] = 8'd0; rld[1] = 8'd200; en[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cnt_f[1] !== exp_c[i][W-1:0]) begin
                errors++; $display("FAIL down_count[%0d] got %0d want %0d", i, cnt_f[1], exp_c[i]);
            end
            checks++; if ({tc_f[1], ovf_f[1]} !== ((i == 2) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL down_tc_ovf[%0d] got %b", i, {tc_f[1], ovf_f[1]});
            end
        end
        tick();
        checks++; if ({cnt_f[1], tc_f[1], ovf_f[1]} !== {8'd198, 1'b0, 1'b1}) begin
            errors++; $display("FAIL down_sticky got cnt=%0d tc=%b ovf=%b want 198 0 1", cnt_f[1], tc_f[1], ovf_f[1]);
        end
        en[1] = 1'b0; clear[1] = 1'b1;
        tick();
        clear[1] = 1'b0;
        checks++; if ({cnt_f[1], ovf_f[1]} !== {8'd0, 1'b0}) begin
            errors++; $display("FAIL down_clear got cnt=%0d ovf=%b want 0 0", cnt_f[1], ovf_f[1]);
        end
    endtask

    task automatic test_up_carry();
        apply_reset();
        load[0] = 1'b1; load_val[0] = 8'd250;
        tick();
        load[0] = 1'b0;
        step[0] = 8'd10; limit[0] = 8'd255; rld[0] = 8'd17; en[0] = 1'b1;
        tick();
        checks++; if ({cnt_f[0], tc_f[0], ovf_f[0]} !== {8'd17, 1'b1, 1'b1}) begin
            errors++; $display("FAIL up_carry got cnt=%0d tc=%b ovf=%b want 17 1 1", cnt_f[0], tc_f[0], ovf_f[0]);
        end
    endtask

    task automatic test_one_shot();
        apply_reset();
        step[0] = 8'd1; limit[0] = 8'd4; en[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if ({cnt_o[0], tc_o[0], done_o[0]} !== {i[W-1:0], (i == 4), (i == 4)}) begin
                errors++; $display("FAIL oneshot_run[%0d] got cnt=%0d tc=%b done=%b", i, cnt_o[0], tc_o[0], done_o[0]);
            end
        end
        tick();
        checks++; if ({cnt_o[0], tc_o[0], done_o[0]} !== {8'd4, 1'b0, 1'b1}) begin
            errors++; $display("FAIL oneshot_hold got cnt=%0d tc=%b done=%b want 4 0 1", cnt_o[0], tc_o[0], done_o[0]);
        end
        load[0] = 1'b1; load_val[0] = 8'd0;
        tick();
        load[0] = 1'b0;
        checks++; if ({cnt_o[0], tc_o[0], done_o[0]} !== {8'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL oneshot_reload got cnt=%0d tc=%b done=%b want 0 0 0", cnt_o[0], tc_o[0], done_o[0]);
        end
        tick();
        checks++; if (cnt_o[0] !== 8'd1) begin errors++; $display("FAIL oneshot_resume got %0d want 1", cnt_o[0]); end
    endtask

    task automatic test_priority();
        apply_reset();
        load[0] = 1'b1; load_val[0] = 8'd9;
        tick();
        clear[0] = 1'b1; load_val[0] = 8'd5; en[0] = 1'b1; step[0] = 8'd1; limit[0] = 8'd200;
        tick();
        checks++; if (cnt_f[0] !== 8'd0) begin errors++; $display("FAIL prio_clear got %0d want 0", cnt_f[0]); end
        clear[0] = 1'b0; load_val[0] = 8'd9; step[0] = 8'd3;
        tick();
        checks++; if (cnt_f[0] !== 8'd9) begin errors++; $display("FAIL prio_load_en got %0d want 9", cnt_f[0]); end
        load[0] = 1'b0; step[0] = 8'd0; limit[0] = 8'd9;
        tick();
        checks++; if ({cnt_f[0], tc_f[0], ovf_f[0]} !== {8'd9, 1'b0, 1'b0}) begin
            errors++; $display("FAIL prio_step0 got cnt=%0d tc=%b ovf=%b want 9 0 0", cnt_f[0], tc_f[0], ovf_f[0]);
        end
        // ch0: 9+1 hits 10 -> rld 2; ch1: 0+5 hits 5 -> rld 1
        step[0] = 8'd1; limit[0] = 8'd10; rld[0] = 8'd2;
        step[1] = 8'd5; limit[1] = 8'd5; rld[1] = 8'd1; en[1] = 1'b1;
        tick();
        checks++; if ({cnt_f[0], cnt_f[1], tc_f[1:0]} !== {8'd2, 8'd1, 2'b11}) begin
            errors++; $display("FAIL prio_dual_hit got c0=%0d c1=%0d tc=%b want 2 1 11", cnt_f[0], cnt_f[1], tc_f[1:0]);
        end
        en[0] = 1'b0;
        step[1] = 8'd1; limit[1] = 8'd100;
        tick();
        checks++; if ({cnt_f[0], cnt_f[1], tc_f[1:0]} !== {8'd2, 8'd2, 2'b00}) begin
            errors++; $display("FAIL prio_indep got c0=%0d c1=%0d tc=%b want 2 2 00", cnt_f[0], cnt_f[1], tc_f[1:0]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step[2] = 8'd8; limit[2] = 8'd4; rld[2] = 8'd0; en[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({cnt_f[2], tc_f[2]} !== {8'd0, 1'b1}) begin
                errors++; $display("FAIL b2b_hit[%0d] got cnt=%0d tc=%b want 0 1", i, cnt_f[2], tc_f[2]);
            end
        end
        en[2] = 1'b0;
        tick();
        checks++; if (tc_f[2] !== 1'b0) begin errors++; $display("FAIL b2b_tc_drop got %b want 0", tc_f[2]); end
    endtask

    initial begin
        test_reset();
        test_free_up();
        test_down_borrow();
        test_up_carry();
        test_one_shot();
        test_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_step_counter.md
# multi_step_counter

Multi-channel programmable step counter with per-channel step size, direction, terminal limit, reload value and sticky overflow. It generalises the single-channel increment-by-one counter into a shared timing/event resource. Peripheral blocks (timers, rate dividers, packet pacers) use it to count in arbitrary strides and receive a one-cycle terminal-count pulse. Each channel runs independently, with either a free-running reload mode or a one-shot mode selected at elaboration.

## Interface
- CounterWidth, 8: width W of every counter, step, limit and reload value; must be ≥ 2.
- NumCh, 4: number of independent channels; must be ≥ 1.
- OneShot, 1'b0: 0 = free-running (reload on terminal), 1 = one-shot (stop at terminal).

Ports:
- clk_i  input  1  rising-edge clock; single clock domain.
- rst_ni  input  1  reset, synchronous, active-low.
- clear_i  input  [NumCh-1:0]  per-channel synchronous clear.
- load_i  input  [NumCh-1:0]  per-channel load of load_val_i.
- load_val_i  input  [NumCh-1:0][W-1:0]  load value.
- en_i  input  [NumCh-1:0]  per-channel count enable.
- down_i  input  [NumCh-1:0]  1 = subtract step, 0 = add step.
- step_i  input  [NumCh-1:0][W-1:0]  step size (unsigned).
- limit_i  input  [NumCh-1:0][W-1:0]  terminal value.
- rld_i  input  [NumCh-1:0][W-1:0]  reload value used at terminal in free-running mode.
- count_o  output  [NumCh-1:0][W-1:0]  current count (registered).
- tc_o  output  [NumCh-1:0]  terminal-count pulse, one cycle (registered).
- ovf_o  output  [NumCh-1:0]  sticky carry/borrow flag (registered).
- done_o  output  [NumCh-1:0]  channel in DONE state (one-shot only; constant 0 when OneShot=0).

## Operation
- Per-channel state machine: ARMED, DONE. Reset, clear_i and load_i all force ARMED. DONE is reachable only when OneShot=1.
- Per-channel priority per cycle: rst_ni low > clear_i > load_i > counting step > hold.
  - clear_i: count := 0, ovf := 0, tc := 0, state := ARMED.
  - load_i: count := load_val_i, ovf := 0, tc := 0, state := ARMED; any en_i in the same cycle is ignored.
- Counting step: taken when en_i=1, state=ARMED and step_i≠0. en_i with step_i=0 is a no-op: count, tc, ovf and state are all unchanged.
- Arithmetic is done in W+1 bits, unsigned.
  - Up: nxt = {0,count}+{0,step}; carry = nxt[W].
  - Down: nxt = {0,count}−{0,step}; borrow = nxt[W].
  - res = nxt[W-1:0].
- Terminal condition (hit):
  - Up: carry | (res ≥ limit).
  - Down: borrow | (res ≤ limit).
- On a counting step:
  - No hit: count := res, tc := 0.
  - Hit, OneShot=0: count := rld_i, tc := 1, state stays ARMED.
  - Hit, OneShot=1: count := limit_i, tc := 1, state := DONE.
  - carry or borrow: ovf := 1, whether or not hit; ovf stays set until clear_i, load_i or reset.
- In DONE: count holds, tc := 0, en_i is ignored. Leave DONE only via clear_i, load_i or reset.
- tc_o is 0 in every cycle that is not the direct result of a hitting step.
- Channels share no state; simultaneous events on different channels are fully independent.

## Timing
- Reset: while rst_ni=0 at a rising edge, each output takes its reset value at that edge: count_o=0, tc_o=0, ovf_o=0, done_o=0, all states ARMED. Inputs are ignored during reset.
- Reset asserted mid-count takes effect at the next edge and overrides clear, load and en.
- Latency is 1 cycle for every input. Inputs sampled at edge N are reflected on count_o, tc_o, ovf_o and done_o after edge N.
- tc_o is asserted in the same cycle the reloaded or limit value appears on count_o, and lasts exactly one cycle.
- Back-to-back hits (e.g. step ≥ limit with rld=0) give tc_o high on consecutive cycles.
- No combinational path from any input to any output.

## Test plan
- Reset: rst_ni low for 2 cycles with en_i all 1 and nonzero steps -> all outputs 0. Assert reset mid-count with ch0=7 -> count_o[0]=0 on the next cycle.
- Free-running up (W=8, OneShot=0): ch0 step=3, limit=10, rld=0, en held -> count 3,6,9,0. tc_o[0]=1 only with the 0; ovf_o[0]=0.
- Down with borrow: load ch1=5, then down, step=2, limit=0, rld=200 -> 3,1,200. tc_o[1]=1 and ovf_o[1]=1 together with 200. ovf stays 1 until clear_i[1], then 0.
- Up carry: ch0 count=250, step=10, limit=255 -> count=rld, tc=1, ovf=1.
- One-shot (OneShot=1): ch0 step=1, limit=4, from 0 -> 1,2,3,4; tc_o[0]=1 and done_o[0]=1 on 4. Further en -> holds 4, tc=0. load_i with load_val=0 -> 0, done_o=0, counting resumes.
- Priority and no-op: clear+load+en in one cycle -> 0. load(9)+en -> 9 with no step. en with step=0 at count=limit -> no tc, count unchanged. ch0 and ch1 hitting in the same cycle -> both tc pulses, independent counts.
